// File: rtl/bcd_converter_8b.sv
// Pipelined 8-bit binary to BCD converter built on shift-and-add-3 stages.
// Also exposes one add-3 correction cell as a standalone combinational port.
module bcd_converter_8b #(
    parameter int LATENCY = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic [7:0] bin_in,
    input  logic [3:0] add3_in,
    output logic [3:0] add3_out,
    output logic       out_valid,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic [1:0] hundreds
);

    function automatic logic [3:0] add3_cell(input logic [3:0] nib);
        logic [3:0] res;
        if (nib >= 4'd5) begin
            res = nib + 4'd3;
        end else begin
            res = nib;
        end
        return res;
    endfunction

    // Scratch layout: [17:16] hundreds, [15:12] tens, [11:8] ones, [7:0] binary.
    // Bit 17 is always zero before a shift, so a rotate equals a left shift.
    function automatic logic [17:0] dd_stage(input logic [17:0] s);
        logic [17:0] c;
        c         = s;
        c[11:8]   = add3_cell(s[11:8]);
        c[15:12]  = add3_cell(s[15:12]);
        return {c[16:0], c[17]};
    endfunction

    logic [17:0] front_s;
    logic [17:0] back_in_s;
    logic [17:0] back_s;
    logic        back_valid_s;
    logic [9:0]  digits_q;
    logic        out_valid_q;

    // Standalone add-3 cell, independent of clock and reset
    always_comb begin
        add3_out = add3_cell(add3_in);
    end

    // First four shift stages
    always_comb begin
        front_s = {10'd0, bin_in};
        for (int i = 0; i < 4; i++) begin
            front_s = dd_stage(front_s);
        end
    end

    generate
        if (LATENCY == 1) begin : g_lat1
            // Back half fed directly from the front half
            always_comb begin
                back_in_s    = front_s;
                back_valid_s = in_valid;
            end
        end else if (LATENCY == 2) begin : g_lat2
            logic [17:0] mid_q;
            logic [17:0] mid_d;
            logic        mid_valid_q;

            // Mid-pipeline capture holds its contents on idle cycles
            always_comb begin
                if (in_valid) begin
                    mid_d = front_s;
                end else begin
                    mid_d = mid_q;
                end
            end

            // Pipeline register after the fourth shift stage
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mid_q       <= 18'd0;
                    mid_valid_q <= 1'b0;
                end else begin
                    mid_q       <= mid_d;
                    mid_valid_q <= in_valid;
                end
            end

            // Back half fed from the pipeline register
            always_comb begin
                back_in_s    = mid_q;
                back_valid_s = mid_valid_q;
            end
        end else begin : g_bad_latency
            $error("bcd_converter_8b: LATENCY must be 1 or 2");
        end
    endgenerate

    // Last four shift stages
    always_comb begin
        back_s = back_in_s;
        for (int i = 0; i < 4; i++) begin
            back_s = dd_stage(back_s);
        end
    end

    // Output register: digits update only on a valid conversion
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            digits_q    <= 10'd0;
            out_valid_q <= 1'b0;
        end else begin
            out_valid_q <= back_valid_s;
            if (back_valid_s) begin
                digits_q <= back_s[17:8];
            end
        end
    end

    assign hundreds  = digits_q[9:8];
    assign tens      = digits_q[7:4];
    assign ones      = digits_q[3:0];
    assign out_valid = out_valid_q;

endmodule

// File: tb/tb_bcd_converter_8b.sv
// Directed bench for bcd_converter_8b, driving a LATENCY=1 and a LATENCY=2
// instance from the same stimulus and checking each against decimal digits.
module tb_bcd_converter_8b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] bin_in = 8'd0;
    logic [3:0] add3_in = 4'd0;

    logic [3:0] add3_out1, add3_out2;
    logic       out_valid1, out_valid2;
    logic [3:0] ones1, tens1, ones2, tens2;
    logic [1:0] hundreds1, hundreds2;

    int n_vec = 0;
    int n_err = 0;

    bcd_converter_8b #(.LATENCY(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bin_in(bin_in),
        .add3_in(add3_in), .add3_out(add3_out1), .out_valid(out_valid1),
        .ones(ones1), .tens(tens1), .hundreds(hundreds1)
    );

    bcd_converter_8b #(.LATENCY(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .bin_in(bin_in),
        .add3_in(add3_in), .add3_out(add3_out2), .out_valid(out_valid2),
        .ones(ones2), .tens(tens2), .hundreds(hundreds2)
    );

    always #5 clk = ~clk;

    function automatic logic [10:0] pack(input logic v, input int n);
        logic [1:0] h;
        logic [3:0] t;
        logic [3:0] o;
        h = 2'(n / 100);
        t = 4'((n / 10) % 10);
        o = 4'(n % 10);
        return {v, h, t, o};
    endfunction

    task automatic chk(input string tag, input logic [10:0] obs, input logic [10:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %03h expected %03h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [10:0] obs1();
        return {out_valid1, hundreds1, tens1, ones1};
    endfunction

    function automatic logic [10:0] obs2();
        return {out_valid2, hundreds2, tens2, ones2};
    endfunction

    initial begin
        logic [3:0] add3_tab [16];
        add3_tab = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd8, 4'd9, 4'd10,
                     4'd11, 4'd12, 4'd13, 4'd14, 4'd15, 4'd0, 4'd1, 4'd2};

        // Reset state
        #2 rst_n = 1'b0;
        repeat (2) tick();
        chk("reset_lat1", obs1(), pack(1'b0, 0));
        chk("reset_lat2", obs2(), pack(1'b0, 0));

        // Add-3 cell over all codes, exercised while reset is held
        for (int a = 0; a < 16; a++) begin
            add3_in = 4'(a);
            #1;
            chk($sformatf("add3_%0d", a), {7'd0, add3_out1}, {7'd0, add3_tab[a]});
            chk($sformatf("add3b_%0d", a), {7'd0, add3_out2}, {7'd0, add3_tab[a]});
        end

        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("idle_lat1", obs1(), pack(1'b0, 0));
        chk("idle_lat2", obs2(), pack(1'b0, 0));

        // Exhaustive sweep 0..255 then wrap to 0
        in_valid = 1'b1;
        for (int i = 0; i <= 256; i++) begin
            bin_in = 8'(i);
            tick();
            chk($sformatf("sweep1_%0d", i), obs1(), pack(1'b1, i % 256));
            if (i == 0) begin
                chk("sweep2_0", obs2(), pack(1'b0, 0));
            end else begin
                chk($sformatf("sweep2_%0d", i), obs2(), pack(1'b1, (i - 1) % 256));
            end
        end

        // Hand-picked spot checks
        chk("hand_128", pack(1'b1, 128), {1'b1, 2'd1, 4'd2, 4'd8});
        chk("hand_255", pack(1'b1, 255), {1'b1, 2'd2, 4'd5, 4'd5});

        // Valid gating: 37 on valid cycles, 250 on idle cycles
        for (int k = 0; k < 8; k++) begin
            in_valid = (k % 2 == 0);
            bin_in   = (k % 2 == 0) ? 8'd37 : 8'd250;
            tick();
            chk($sformatf("gate1_%0d", k), obs1(), {(k % 2 == 0), 2'd0, 4'd3, 4'd7});
            if (k == 0) begin
                chk("gate2_0", obs2(), pack(1'b1, 0));
            end else begin
                chk($sformatf("gate2_%0d", k), obs2(), {((k - 1) % 2 == 0), 2'd0, 4'd3, 4'd7});
            end
        end

        // Reset mid-operation between clock edges
        in_valid = 1'b1;
        bin_in   = 8'd255;
        tick();
        chk("pre_rst1_a", obs1(), {1'b1, 2'd2, 4'd5, 4'd5});
        tick();
        chk("pre_rst1_b", obs1(), {1'b1, 2'd2, 4'd5, 4'd5});
        chk("pre_rst2", obs2(), {1'b1, 2'd2, 4'd5, 4'd5});
        #2 rst_n = 1'b0;
        #1;
        chk("async_rst1", obs1(), 11'd0);
        chk("async_rst2", obs2(), 11'd0);
        in_valid = 1'b0;
        @(negedge clk) rst_n = 1'b1;
        tick();
        chk("post_rst1", obs1(), 11'd0);
        chk("post_rst2", obs2(), 11'd0);
        in_valid = 1'b1;
        bin_in   = 8'd64;
        tick();
        chk("first64_1", obs1(), {1'b1, 2'd0, 4'd6, 4'd4});
        chk("first64_2a", obs2(), 11'd0);
        in_valid = 1'b0;
        tick();
        chk("hold64_1", obs1(), {1'b0, 2'd0, 4'd6, 4'd4});
        chk("first64_2b", obs2(), {1'b1, 2'd0, 4'd6, 4'd4});

        // Back-to-back 1, 2, 3
        in_valid = 1'b1;
        for (int j = 1; j <= 5; j++) begin
            if (j <= 3) begin
                bin_in = 8'(j);
            end else begin
                in_valid = 1'b0;
                bin_in   = 8'd99;
            end
            tick();
            chk($sformatf("b2b1_%0d", j), obs1(),
                (j <= 3) ? pack(1'b1, j) : pack(1'b0, 3));
            case (j)
                1:       chk("b2b2_1", obs2(), {1'b0, 2'd0, 4'd6, 4'd4});
                2:       chk("b2b2_2", obs2(), {1'b1, 2'd0, 4'd0, 4'd1});
                3:       chk("b2b2_3", obs2(), {1'b1, 2'd0, 4'd0, 4'd2});
                4:       chk("b2b2_4", obs2(), {1'b1, 2'd0, 4'd0, 4'd3});
                default: chk("b2b2_5", obs2(), {1'b0, 2'd0, 4'd0, 4'd3});
            endcase
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/bcd_converter_8b.md
Name: bcd_converter_8b

Overview:
- Clocked binary-to-BCD converter for unsigned 8-bit values (0..255) using the shift-and-add-3 (double-dabble) algorithm.
- The datapath is built from 4-bit add-3 correction cells. One cell is also exposed on a standalone combinational port for unit checking.
- Sits between a binary counter or datapath and decimal display or reporting logic. Produces HUNDREDS/TENS/ONES digits with a fixed pipeline latency.

Parameters:
- LATENCY, default 1: clock cycles from input sample to registered digit output.
  - Legal values are 1 and 2.
  - At 2, an internal pipeline register sits after the 4th shift stage.
  - Any other value is a synthesis-time error.

Ports:
- clk  input  1  Single clock; all state updates on its rising edge.
- rst_n  input  1  Asynchronous reset, active-low; asserts immediately, deasserts synchronously to clk.
- in_valid  input  1  Qualifies bin_in; sampled every rising edge.
- bin_in  input  8  Unsigned binary value to convert.
- add3_in  input  4  Operand for the standalone add-3 cell.
- add3_out  output  4  Combinational add-3 cell result.
- out_valid  output  1  High when the digit outputs hold a fresh conversion.
- ones  output  4  BCD units digit, 0..9.
- tens  output  4  BCD tens digit, 0..9.
- hundreds  output  2  BCD hundreds digit, 0..2.

Behaviour:
- Add-3 cell (combinational, no clock involvement):
  - add3_out = add3_in when add3_in <= 4.
  - add3_out = (add3_in + 3) mod 16 when add3_in >= 5.
  - Fully defined for all 16 codes: 5→8, 6→9, 7→10, 8→11, 9→12, 10→13, 11→14, 12→15, 13→0, 14→1, 15→2.
  - The same cell function is instantiated inside the conversion datapath.
- Conversion:
  - Standard 8-iteration double-dabble on a 10-bit BCD scratch field plus the 8-bit binary.
  - Before each shift, the add-3 cell is applied to every BCD nibble that can hold ≥5 at that stage.
  - All 8 stages are unrolled combinationally, with no iterative FSM.
  - Result: hundreds = bin_in/100, tens = (bin_in/10) mod 10, ones = bin_in mod 10.
  - Every digit is always in legal BCD range for any 8-bit input; no overflow case exists.
- Latency and handshake:
  - LATENCY=1: on a rising edge with in_valid=1, digits of bin_in are registered and out_valid=1 for the next cycle.
  - LATENCY=1: on a rising edge with in_valid=0, out_valid=0 and the digit registers hold their previous values.
  - LATENCY=2: the same behaviour, delayed by one additional cycle; the valid bit travels alongside the data stage.
  - No backpressure: one conversion per clock is accepted, and back-to-back inputs give back-to-back outputs.
- Reset:
  - While rst_n=0: ones=0, tens=0, hundreds=0, out_valid=0, and all internal pipeline registers are 0.
  - Reset asserted mid-stream discards in-flight conversions immediately, regardless of clk.
  - First valid output after release appears LATENCY cycles after the first sampled in_valid=1.
- add3_out is unaffected by clk and rst_n.

Test Plan:
- Exhaustive sweep:
  - Stimulus: rst_n released, in_valid=1, bin_in incremented by 1 every clock from 0 through 255 and wrapping to 0.
  - Required response: each output equals the decimal digits of the input LATENCY cycles earlier. Examples: 0→0/0/0, 9→0/0/9, 10→0/1/0, 99→0/9/9, 100→1/0/0, 128→1/2/8, 199→1/9/9, 200→2/0/0, 255→2/5/5. Then 0→0/0/0 after the wrap.
- Add-3 cell:
  - Stimulus: add3_in driven 0..15.
  - Required response: 0..4 pass through unchanged, 5→8, 9→12, 10→13, 12→15, 13→0, 15→2.
- Valid gating:
  - Stimulus: alternate in_valid 1/0 with bin_in=37 on valid cycles and 250 on invalid cycles.
  - Required response: out_valid toggles with LATENCY-cycle lag and digits stay 0/3/7; 250 is never captured.
- Reset mid-operation:
  - Stimulus: assert rst_n=0 asynchronously between edges while out_valid=1 with digits 2/5/5.
  - Required response: outputs go to 0/0/0 and out_valid=0 immediately.
  - After release, the first valid input of 64 yields 0/6/4 after LATENCY cycles.
- LATENCY=2 build:
  - Stimulus: back-to-back inputs 1, 2, 3.
  - Required response: digits 0/0/1, 0/0/2, 0/0/3 appear on consecutive cycles starting two cycles after the first sample.
